// File: rtl/parity_link_sched.sv
// parity_link_sched: round-robin scheduler for two requesters sharing one serial link.
// Each frame is sent LSB first: start bit, DW data bits, even-parity bit, then one idle gap cycle.
`default_nettype none

module parity_link_sched #(
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          ser_out,
  output logic          ser_en,
  output logic          frame_start,
  output logic          frame_done,
  output logic          busy,
  output logic          grant_id
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_shreg;
  logic          r_par;
  logic [CW-1:0] r_cnt;
  logic          r_grant_id;
  logic          r_last_grant;
  logic          w_idle;

  assign w_idle = (r_state == S_IDLE);

  // Ready is gated by rst so that no handshake can complete while reset is held.
  assign req0_ready = rst & w_idle & req0_valid & (~req1_valid | r_last_grant);
  assign req1_ready = rst & w_idle & req1_valid & (~req0_valid | ~r_last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_par        <= 1'b0;
      r_cnt        <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_ready) begin
            r_shreg      <= req0_data;
            r_par        <= 1'b0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= S_START;
          end else if (req1_ready) begin
            r_shreg      <= req1_data;
            r_par        <= 1'b0;
            r_grant_id   <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_shreg <= r_shreg >> 1;
          r_par   <= r_par ^ r_shreg[0];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(DW - 1)) begin
            r_state <= S_PARITY;
          end
        end
        S_PARITY: r_state <= S_GAP;
        S_GAP:    r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ser_out     = 1'b1;
    ser_en      = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_START: begin
        ser_out     = 1'b0;
        ser_en      = 1'b1;
        frame_start = 1'b1;
      end
      S_DATA: begin
        ser_out = r_shreg[0];
        ser_en  = 1'b1;
      end
      S_PARITY: begin
        ser_out    = r_par;
        ser_en     = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = ~w_idle;
  assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_parity_link_sched.sv
// tb_parity_link_sched: randomized and directed stimulus checked against a frame-schedule model.
`default_nettype none

module tb_parity_link_sched;

  localparam int DW = 3;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          ser_out;
  logic          ser_en;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  logic          grant_id;

  parity_link_sched #(.DW(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .ser_out    (ser_out),
    .ser_en     (ser_en),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  // Model: the link is free from cycle m_next_free; a frame accepted at m_acc
  // occupies cycles m_acc+1 .. m_acc+DW+3.
  int            m_next_free = 0;
  int            m_acc = 0;
  logic          m_last = 1'b1;
  logic          m_gid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          e_r0;
  logic          e_r1;

  task automatic chk(input string tag, input logic obs, input logic req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", tag, obs, req, t);
    end
  endtask

  task automatic step(input logic rv, input logic v0, input logic [DW-1:0] d0,
                      input logic v1, input logic [DW-1:0] d1);
    logic eo, een, efs, efd, eb;
    int   p;
    @(negedge clk);
    rst        = rv;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    e_r0 = 1'b0; e_r1 = 1'b0;
    eo = 1'b1; een = 1'b0; efs = 1'b0; efd = 1'b0; eb = 1'b0;
    if (!rv) begin
      m_gid  = 1'b0;
      m_last = 1'b1;
    end else if (t >= m_next_free) begin
      e_r0 = v0 && (!v1 || m_last);
      e_r1 = v1 && (!v0 || !m_last);
    end else begin
      p  = t - m_acc - 1;
      eb = 1'b1;
      if (p == 0) begin
        eo = 1'b0; een = 1'b1; efs = 1'b1;
      end else if (p <= DW) begin
        eo = m_data[p-1]; een = 1'b1;
      end else if (p == DW + 1) begin
        eo = ^m_data; een = 1'b1; efd = 1'b1;
      end
    end
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("ser_out", ser_out, eo);
    chk("ser_en", ser_en, een);
    chk("frame_start", frame_start, efs);
    chk("frame_done", frame_done, efd);
    chk("busy", busy, eb);
    chk("grant_id", grant_id, m_gid);
    if (!rv) begin
      m_next_free = t + 1;
    end else if (e_r0 || e_r1) begin
      m_acc       = t;
      m_data      = e_r0 ? d0 : d1;
      m_gid       = e_r1;
      m_last      = e_r1;
      m_next_free = t + DW + 4;
    end
    t++;
  endtask

  logic          h0, h1;
  logic [DW-1:0] g0, g1;

  initial begin
    rst = 1'b0; req0_valid = 1'b0; req0_data = '0; req1_valid = 1'b0; req1_data = '0;
    h0 = 1'b0; h1 = 1'b0; g0 = '0; g1 = '0;

    // Single requester frames, then contention from reset.
    repeat (2) step(1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b101, 1'b0, 3'b000);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000, 1'b1, 3'b111);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step(1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    repeat (28) step(1'b1, 1'b1, 3'b001, 1'b1, 3'b110);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b0, 3'b000);

    // Continuous single requester and data change after acceptance.
    repeat (21) step(1'b1, 1'b1, 3'b000, 1'b0, 3'b000);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b101, 1'b0, 3'b000);
    repeat (8) step(1'b1, 1'b0, 3'b010, 1'b0, 3'b000);

    // Reset in the second DATA cycle, then both requesters pending.
    step(1'b1, 1'b1, 3'b101, 1'b0, 3'b000);
    repeat (2) step(1'b1, 1'b0, 3'b101, 1'b1, 3'b011);
    step(1'b0, 1'b1, 3'b101, 1'b1, 3'b011);
    step(1'b1, 1'b1, 3'b101, 1'b1, 3'b011);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b1, 3'b011);
    step(1'b0, 1'b0, 3'b000, 1'b1, 3'b011);
    repeat (8) step(1'b1, 1'b0, 3'b000, 1'b1, 3'b011);

    // Randomized traffic: a requester keeps its word until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!h0 && $urandom_range(0, 2) == 0) begin h0 = 1'b1; g0 = DW'($urandom); end
      if (!h1 && $urandom_range(0, 2) == 0) begin h1 = 1'b1; g1 = DW'($urandom); end
      step(($urandom_range(0, 199) != 0), h0, g0, h1, g1);
      if (e_r0) begin h0 = 1'($urandom_range(0, 1)); g0 = DW'($urandom); end
      if (e_r1) begin h1 = 1'($urandom_range(0, 1)); g1 = DW'($urandom); end
      if (!h0 && $urandom_range(0, 3) == 0) g0 = DW'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parity_link_sched.md
Name: parity_link_sched

Overview:
- Two-requester scheduler and serializer for the shared single-wire even-parity serial link.
- Each requester presents a DW-bit word with a valid/ready handshake.
- The block grants the link round-robin and captures the granted word.
- It then drives one frame on the link, LSB first: start bit, DW data bits, even-parity bit, one idle gap cycle.

Parameters:
- DW, 3, data bits per frame; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req0_valid  input  1  requester 0 has a word
- req0_data  input  DW  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  DW  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- ser_out  output  1  serial link bit
- ser_en  output  1  ser_out carries a frame bit this cycle
- frame_start  output  1  start bit on ser_out this cycle
- frame_done  output  1  parity (last) bit on ser_out this cycle
- busy  output  1  frame in progress (state != IDLE)
- grant_id  output  1  requester owning the current or most recent frame

Behaviour:
- States: IDLE, START, DATA, PARITY, GAP. Binary-encoded state register; bit counter of clog2(DW+1) bits.
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, parity accumulator=0, counter=0.
  - grant_id=0; last-grant pointer=1, so requester 0 wins the first contention.
  - Outputs: ser_out=1, ser_en=0, frame_start=0, frame_done=0, busy=0, both ready=0.
- Outputs are Moore-decoded from state, except the ready signals.
- Arbitration, IDLE only:
  - req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1).
  - req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0).
  - At most one ready is high per cycle. A transfer occurs when valid & ready on the same edge.
- On transfer:
  - Capture the granted data into the shift register and clear the parity accumulator.
  - grant_id and last_grant take the granted id.
  - Next state START.
- IDLE with no valid: remain in IDLE, ser_out=1, ser_en=0.
- START: ser_out=0, ser_en=1, frame_start=1, counter=0; next DATA.
- DATA:
  - ser_out=shreg[0], ser_en=1.
  - Each cycle: shift right, XOR the emitted bit into parity, increment counter.
  - After DW cycles (counter==DW-1 on exit), next PARITY.
- PARITY:
  - ser_out = XOR of the DW data bits, so the count of ones in data+parity is even.
  - ser_en=1, frame_done=1; next GAP.
- GAP: ser_out=1, ser_en=0, busy=1, both ready=0; next IDLE.
- Timing:
  - The frame occupies DW+3 cycles after the accept edge.
  - Back-to-back frames repeat every DW+4 cycles: the accept cycle in IDLE plus START, DW×DATA, PARITY, GAP. For DW=3 the period is 7 cycles.
- Data changes on reqN_data after acceptance have no effect on the frame in flight.
- A requester holding valid while not granted keeps its word; nothing is dropped or duplicated.
- Reset asserted mid-frame:
  - Aborts immediately; outputs take reset values in the same cycle.
  - The partial frame is discarded; no frame_done is issued.
  - The requester already accepted is not re-served.
- Single requester valid continuously: it is granted every IDLE visit; fairness applies only under contention.

Test Plan:
- Reset, then req0_valid=1, req0_data=3'b101:
  - req0_ready pulses 1 cycle; ser_out over the ser_en cycles = 0,1,0,1,0.
  - frame_start on the 1st bit, frame_done on the 5th; grant_id=0.
- req1_data=3'b111 alone: ser_out = 0,1,1,1,1 (parity 1); grant_id=1; busy high 6 cycles, then low.
- Both valid from reset with req0=3'b001 and req1=3'b110:
  - req0 is served first (parity 1), then req1 (parity 0).
  - req1_ready rises exactly 7 cycles after req0_ready.
  - While both stay valid, grants alternate 0,1,0,1.
- req0_data=3'b000 with valid held high for 3 frames:
  - Frames of 0,0,0,0,0, each separated by one ser_en=0 GAP cycle and one IDLE accept cycle.
  - Exactly 3 ready pulses.
- rst driven low in the 2nd DATA cycle:
  - Immediately ser_en=0, ser_out=1, busy=0, no frame_done.
  - After release, a pending req1 wins only if req0 is not valid; otherwise req0 wins because last_grant was reset.
- Change req0_data from 3'b101 to 3'b010 one cycle after acceptance: the transmitted bits stay 0,1,0,1,0.
